// File: rtl/alu_reservation_station.sv
// ALU reservation station: DEPTH entries with CDB wakeup, zero-latency dispatch and flush.
// Define LEN5_RS_RR_SEL_EN for round-robin dispatch selection; otherwise lowest ready index wins.
package alu_rs_pkg;
    localparam int XLEN           = 64;
    localparam int MAX_EU_CTL_LEN = 8;
    localparam int ROB_IDX_LEN    = 4;

    typedef logic [MAX_EU_CTL_LEN-1:0] alu_ctl_t;
    typedef logic [ROB_IDX_LEN-1:0]    rob_idx_t;

    typedef struct packed {
        logic            ready;
        rob_idx_t        rob_idx;
        logic [XLEN-1:0] value;
    } op_data_t;

    typedef struct packed {
        rob_idx_t        rob_idx;
        logic [XLEN-1:0] res_value;
        logic            except_raised;
        logic [4:0]      except_code;
    } cdb_data_t;
endpackage

module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [MAX_EU_CTL_LEN-1:0] issue_ctl_i,
    input  op_data_t                  issue_rs1_i,
    input  op_data_t                  issue_rs2_i,
    input  rob_idx_t                  issue_dest_rob_idx_i,
    output logic                      eu_valid_o,
    input  logic                      eu_ready_i,
    output logic [MAX_EU_CTL_LEN-1:0] eu_ctl_o,
    output logic [XLEN-1:0]           eu_rs1_value_o,
    output logic [XLEN-1:0]           eu_rs2_value_o,
    output rob_idx_t                  eu_rob_idx_o,
    input  logic                      cdb_valid_i,
    input  cdb_data_t                 cdb_data_i
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        alu_ctl_t        ctl;
        logic            rs1_ready;
        rob_idx_t        rs1_idx;
        logic [XLEN-1:0] rs1_value;
        logic            rs2_ready;
        rob_idx_t        rs2_idx;
        logic [XLEN-1:0] rs2_value;
        rob_idx_t        dest;
    } entry_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    entry_t           new_entry;
    logic             hold_q, hold_d;
    logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
    logic [DEPTH-1:0] ready_vec;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic             free_found, sel_found, insert, dispatch;
`ifdef LEN5_RS_RR_SEL_EN
    logic [IDX_W-1:0] ptr_q, ptr_d, cand;
`endif

    logic unused_except;
    assign unused_except = ^{cdb_data_i.except_raised, cdb_data_i.except_code};

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid_q[i] & entry_q[i].rs1_ready & entry_q[i].rs2_ready;
            if (!valid_q[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // A stalled dispatch pins the selection so eu_* stay stable until accepted.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
`ifdef LEN5_RS_RR_SEL_EN
        cand = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (ready_vec[cand] && !sel_found) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ready_vec[i] && !sel_found) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
`endif
        if (hold_q) begin
            sel_idx   = hold_idx_q;
            sel_found = 1'b1;
        end
    end

    assign issue_ready_o  = free_found;
    assign eu_valid_o     = sel_found && !flush_i;
    assign insert         = issue_valid_i && issue_ready_o;
    assign dispatch       = eu_valid_o && eu_ready_i;
    assign eu_ctl_o       = entry_q[sel_idx].ctl;
    assign eu_rs1_value_o = entry_q[sel_idx].rs1_value;
    assign eu_rs2_value_o = entry_q[sel_idx].rs2_value;
    assign eu_rob_idx_o   = entry_q[sel_idx].dest;

    always_comb begin
        new_entry.ctl       = issue_ctl_i;
        new_entry.dest      = issue_dest_rob_idx_i;
        new_entry.rs1_idx   = issue_rs1_i.rob_idx;
        new_entry.rs2_idx   = issue_rs2_i.rob_idx;
        new_entry.rs1_ready = issue_rs1_i.ready;
        new_entry.rs1_value = issue_rs1_i.value;
        new_entry.rs2_ready = issue_rs2_i.ready;
        new_entry.rs2_value = issue_rs2_i.value;
        if (!issue_rs1_i.ready && cdb_valid_i && issue_rs1_i.rob_idx == cdb_data_i.rob_idx) begin
            new_entry.rs1_ready = 1'b1;
            new_entry.rs1_value = cdb_data_i.res_value;
        end
        if (!issue_rs2_i.ready && cdb_valid_i && issue_rs2_i.rob_idx == cdb_data_i.rob_idx) begin
            new_entry.rs2_ready = 1'b1;
            new_entry.rs2_value = cdb_data_i.res_value;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (valid_q[i] && cdb_valid_i) begin
                if (!entry_q[i].rs1_ready && entry_q[i].rs1_idx == cdb_data_i.rob_idx) begin
                    entry_d[i].rs1_ready = 1'b1;
                    entry_d[i].rs1_value = cdb_data_i.res_value;
                end
                if (!entry_q[i].rs2_ready && entry_q[i].rs2_idx == cdb_data_i.rob_idx) begin
                    entry_d[i].rs2_ready = 1'b1;
                    entry_d[i].rs2_value = cdb_data_i.res_value;
                end
            end
        end
        if (insert) entry_d[free_idx] = new_entry;
    end

    always_comb begin
        valid_d = valid_q;
        if (dispatch) valid_d[sel_idx] = 1'b0;
        if (insert) valid_d[free_idx] = 1'b1;
        if (flush_i) valid_d = '0;
        hold_d     = eu_valid_o && !eu_ready_i;
        hold_idx_d = sel_idx;
`ifdef LEN5_RS_RR_SEL_EN
        ptr_d = ptr_q;
        if (dispatch) ptr_d = sel_idx + IDX_W'(1);
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
`ifdef LEN5_RS_RR_SEL_EN
            ptr_q      <= '0;
`endif
        end else begin
            valid_q    <= valid_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
`ifdef LEN5_RS_RR_SEL_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        entry_q <= entry_d;
    end
endmodule
